esm_instr_buffer: RTL and testbench

- Producer side of the ESM core interface: owns the bs-entry instruction window that the core's dependence-analysis and issue logic scans.
- Accepts instructions from fetch over a valid/ready handshake and places each into the lowest free slot.
- Presents each newly written instruction and its slot index to the core, and publishes the per-slot valid vector.
- Consumes the core's issue selection, which is a slot index plus a valid flag. It emits the selected instruction downstream and frees that slot. A drain FSM supports pipeline flush.

---
 rtl/esm_pkg.sv | 15 +
 rtl/esm_free_slot_finder.sv | 23 ++
 rtl/esm_instr_buffer.sv | 135 +++++++++++++
 tb/tb_esm_instr_buffer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/esm_pkg.sv
// Shared ESM definitions: default widths and the drain FSM state encoding,
// used by both the core and the instruction buffer.
package esm_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned BS      = 16;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2,
        HOLD  = 2'd3
    } esm_state_e;

endpackage

// File: rtl/esm_free_slot_finder.sv
// Lowest-zero priority encoder over the slot occupancy vector.
module esm_free_slot_finder #(
    parameter  int unsigned bs = 16,
    localparam int unsigned IW = $clog2(bs)
) (
    input  logic [0:bs-1]  valid_entries_i,
    output logic [IW-1:0]  slot_o,
    output logic           any_free_o
);

    // Scan high to low so the lowest free index wins.
    always_comb begin
        slot_o = '0;
        for (int i = int'(bs) - 1; i >= 0; i--) begin
            if (!valid_entries_i[i]) begin
                slot_o = IW'(i);
            end
        end
    end

    assign any_free_o = ~&valid_entries_i;

endmodule

// File: rtl/esm_instr_buffer.sv
// Instruction window feeding the ESM core: lowest-free-slot fill from fetch,
// indexed issue/free from the core, and a drain FSM for pipeline flush.
module esm_instr_buffer
    import esm_pkg::*;
#(
    parameter int unsigned Instruction_word_size = INSTR_W,
    parameter int unsigned bs                    = BS
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             fetch_valid,
    input  logic [Instruction_word_size-1:0] fetch_instr,
    output logic                             fetch_ready,
    output logic [Instruction_word_size-1:0] core_instr,
    output logic [$clog2(bs)-1:0]            core_index,
    output logic                             core_wr,
    output logic [0:bs-1]                    valid_entries,
    input  logic                             issue_valid,
    input  logic [$clog2(bs)-1:0]            issue_index,
    output logic [Instruction_word_size-1:0] issued_instr,
    output logic                             issued_valid,
    output logic                             issue_err,
    input  logic                             drain_req,
    output logic                             drain_done,
    output logic [$clog2(bs):0]              occupancy
);

    localparam int unsigned IW = $clog2(bs);
    localparam int unsigned OW = IW + 1;
    localparam int unsigned DW = Instruction_word_size;

    esm_state_e           state_q, state_d;
    logic [DW-1:0]        mem_q [bs];
    logic [0:bs-1]        valid_q, valid_d;
    logic [OW-1:0]        occ_q, occ_d;
    logic [DW-1:0]        core_instr_q, issued_instr_q;
    logic [IW-1:0]        core_index_q;
    logic                 core_wr_q, issued_valid_q, issue_err_q;
    logic [IW-1:0]        free_slot;
    logic                 any_free;
    logic                 accept;
    logic                 issue_hit;

    esm_free_slot_finder #(.bs(bs)) u_finder (
        .valid_entries_i (valid_q),
        .slot_o          (free_slot),
        .any_free_o      (any_free)
    );

    assign accept    = fetch_valid && fetch_ready;
    assign issue_hit = issue_valid && valid_q[issue_index];

    // Both searches use pre-edge occupancy, so accept and issue never target the same slot.
    always_comb begin
        valid_d = valid_q;
        if (accept) begin
            valid_d[free_slot] = 1'b1;
        end
        if (issue_hit) begin
            valid_d[issue_index] = 1'b0;
        end
        unique case ({accept, issue_hit})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (drain_req) state_d = DRAIN;
            DRAIN:   if (occ_d == '0) state_d = DONE;
            DONE:    state_d = drain_req ? HOLD : RUN;
            HOLD:    if (!drain_req) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Reset gates fetch_ready so fetch sees no ready while the window is cleared.
    always_comb begin
        fetch_ready = rst && (state_q == RUN) && any_free;
        drain_done  = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[free_slot] <= fetch_instr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q        <= '0;
            occ_q          <= '0;
            core_instr_q   <= '0;
            core_index_q   <= '0;
            core_wr_q      <= 1'b0;
            issued_instr_q <= '0;
            issued_valid_q <= 1'b0;
            issue_err_q    <= 1'b0;
        end else begin
            valid_q        <= valid_d;
            occ_q          <= occ_d;
            core_wr_q      <= accept;
            issued_valid_q <= issue_hit;
            issue_err_q    <= issue_valid && !issue_hit;
            if (accept) begin
                core_instr_q <= fetch_instr;
                core_index_q <= free_slot;
            end
            if (issue_hit) begin
                issued_instr_q <= mem_q[issue_index];
            end
        end
    end

    assign valid_entries = valid_q;
    assign occupancy     = occ_q;
    assign core_instr    = core_instr_q;
    assign core_index    = core_index_q;
    assign core_wr       = core_wr_q;
    assign issued_instr  = issued_instr_q;
    assign issued_valid  = issued_valid_q;
    assign issue_err     = issue_err_q;

endmodule

// File: tb/tb_esm_instr_buffer.sv
// Directed self-checking bench for esm_instr_buffer (32-bit words, 16 slots).
module tb_esm_instr_buffer;

    logic        clk;
    logic        rst;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        fetch_ready;
    logic [31:0] core_instr;
    logic [3:0]  core_index;
    logic        core_wr;
    logic [0:15] valid_entries;
    logic        issue_valid;
    logic [3:0]  issue_index;
    logic [31:0] issued_instr;
    logic        issued_valid;
    logic        issue_err;
    logic        drain_req;
    logic        drain_done;
    logic [4:0]  occupancy;

    int tests;
    int fails;

    esm_instr_buffer #(.Instruction_word_size(32), .bs(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_valid   (fetch_valid),
        .fetch_instr   (fetch_instr),
        .fetch_ready   (fetch_ready),
        .core_instr    (core_instr),
        .core_index    (core_index),
        .core_wr       (core_wr),
        .valid_entries (valid_entries),
        .issue_valid   (issue_valid),
        .issue_index   (issue_index),
        .issued_instr  (issued_instr),
        .issued_valid  (issued_valid),
        .issue_err     (issue_err),
        .drain_req     (drain_req),
        .drain_done    (drain_done),
        .occupancy     (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic fetch_one(input logic [31:0] instr);
        fetch_valid = 1'b1;
        fetch_instr = instr;
        tick();
        fetch_valid = 1'b0;
    endtask

    task automatic issue_one(input logic [3:0] idx);
        issue_valid = 1'b1;
        issue_index = idx;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        tests++;
        if ({fetch_ready, core_wr, issued_valid, issue_err, drain_done} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags got %b exp 00000",
                     {fetch_ready, core_wr, issued_valid, issue_err, drain_done});
        end
        tests++;
        if (valid_entries !== 16'h0 || occupancy !== 5'd0 || core_index !== 4'd0) begin
            fails++;
            $display("FAIL reset_state valid=%h occ=%0d idx=%0d exp 0/0/0",
                     valid_entries, occupancy, core_index);
        end
        tick();
        rst = 1'b1;
        #1;
        tests++;
        if (fetch_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready got %b exp 1", fetch_ready);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            fetch_valid = 1'b1;
            fetch_instr = 32'h1000 + 32'(i);
            #1;
            tests++;
            if (fetch_ready !== 1'b1) begin
                fails++;
                $display("FAIL fill_ready[%0d] got %b exp 1", i, fetch_ready);
            end
            tick();
            tests++;
            if (core_wr !== 1'b1 || core_index !== 4'(i) || core_instr !== 32'h1000 + 32'(i)
                || occupancy !== 5'(i + 1)) begin
                fails++;
                $display("FAIL fill_write[%0d] wr=%b idx=%0d instr=%h occ=%0d exp 1/%0d/%h/%0d",
                         i, core_wr, core_index, core_instr, occupancy, i,
                         32'h1000 + 32'(i), i + 1);
            end
        end
        fetch_valid = 1'b0;
        #1;
        tests++;
        if (valid_entries !== 16'hFFFF || occupancy !== 5'd16 || fetch_ready !== 1'b0) begin
            fails++;
            $display("FAIL fill_full valid=%h occ=%0d ready=%b exp FFFF/16/0",
                     valid_entries, occupancy, fetch_ready);
        end
        tick();
        tests++;
        if (core_wr !== 1'b0 || core_index !== 4'd15) begin
            fails++;
            $display("FAIL fill_idle wr=%b idx=%0d exp 0/15", core_wr, core_index);
        end
    endtask

    task automatic test_issue_free();
        issue_one(4'd5);
        tests++;
        if (issued_valid !== 1'b1 || issued_instr !== 32'h1005) begin
            fails++;
            $display("FAIL issue5 valid=%b instr=%h exp 1/00001005", issued_valid, issued_instr);
        end
        tests++;
        if (valid_entries[5] !== 1'b0 || occupancy !== 5'd15 || fetch_ready !== 1'b1) begin
            fails++;
            $display("FAIL issue5_state bit5=%b occ=%0d ready=%b exp 0/15/1",
                     valid_entries[5], occupancy, fetch_ready);
        end
        tick();
        tests++;
        if (issued_valid !== 1'b0 || issue_err !== 1'b0) begin
            fails++;
            $display("FAIL issue5_pulse valid=%b err=%b exp 0/0", issued_valid, issue_err);
        end
        fetch_one(32'hABCD);
        tests++;
        if (core_wr !== 1'b1 || core_index !== 4'd5 || core_instr !== 32'hABCD
            || occupancy !== 5'd16) begin
            fails++;
            $display("FAIL refill5 wr=%b idx=%0d instr=%h occ=%0d exp 1/5/0000abcd/16",
                     core_wr, core_index, core_instr, occupancy);
        end
    endtask

    task automatic test_simultaneous();
        fetch_valid = 1'b1;
        fetch_instr = 32'h5555;
        issue_valid = 1'b1;
        issue_index = 4'd3;
        #1;
        tests++;
        if (fetch_ready !== 1'b0) begin
            fails++;
            $display("FAIL sim_ready_full got %b exp 0", fetch_ready);
        end
        tick();
        issue_valid = 1'b0;
        tests++;
        if (issued_instr !== 32'h1003 || core_wr !== 1'b0 || occupancy !== 5'd15
            || fetch_ready !== 1'b1) begin
            fails++;
            $display("FAIL sim_issue3 instr=%h wr=%b occ=%0d ready=%b exp 00001003/0/15/1",
                     issued_instr, core_wr, occupancy, fetch_ready);
        end
        tick();
        fetch_valid = 1'b0;
        tests++;
        if (core_wr !== 1'b1 || core_index !== 4'd3 || occupancy !== 5'd16) begin
            fails++;
            $display("FAIL sim_accept3 wr=%b idx=%0d occ=%0d exp 1/3/16",
                     core_wr, core_index, occupancy);
        end
    endtask

    task automatic test_back_to_back();
        issue_one(4'd9);
        fetch_valid = 1'b1;
        fetch_instr = 32'h6666;
        issue_valid = 1'b1;
        issue_index = 4'd4;
        tick();
        fetch_valid = 1'b0;
        issue_valid = 1'b0;
        tests++;
        if (core_index !== 4'd9 || core_wr !== 1'b1 || issued_valid !== 1'b1
            || issued_instr !== 32'h1004 || occupancy !== 5'd15) begin
            fails++;
            $display("FAIL b2b idx=%0d wr=%b iv=%b instr=%h occ=%0d exp 9/1/1/00001004/15",
                     core_index, core_wr, issued_valid, issued_instr, occupancy);
        end
        tests++;
        if (valid_entries !== 16'hF7FF) begin
            fails++;
            $display("FAIL b2b_valid got %h exp f7ff", valid_entries);
        end
    endtask

    task automatic test_empty_issue();
        do_reset();
        issue_one(4'd7);
        tests++;
        if (issue_err !== 1'b1 || issued_valid !== 1'b0 || valid_entries !== 16'h0
            || occupancy !== 5'd0) begin
            fails++;
            $display("FAIL empty_issue err=%b iv=%b valid=%h occ=%0d exp 1/0/0000/0",
                     issue_err, issued_valid, valid_entries, occupancy);
        end
        tick();
        tests++;
        if (issue_err !== 1'b0) begin
            fails++;
            $display("FAIL empty_issue_pulse got %b exp 0", issue_err);
        end
    endtask

    task automatic test_drain();
        do_reset();
        fetch_one(32'hA0);
        fetch_one(32'hA1);
        fetch_one(32'hA2);
        drain_req = 1'b1;
        tick();
        tests++;
        if (fetch_ready !== 1'b0 || drain_done !== 1'b0) begin
            fails++;
            $display("FAIL drain_enter ready=%b done=%b exp 0/0", fetch_ready, drain_done);
        end
        for (int i = 0; i < 3; i++) begin
            issue_one(4'(i));
            tests++;
            if (drain_done !== (i == 2) || occupancy !== 5'(2 - i) || issued_valid !== 1'b1) begin
                fails++;
                $display("FAIL drain_issue[%0d] done=%b occ=%0d iv=%b exp %0d/%0d/1",
                         i, drain_done, occupancy, issued_valid, i == 2, 2 - i);
            end
        end
        tick();
        tests++;
        if (drain_done !== 1'b0 || fetch_ready !== 1'b0) begin
            fails++;
            $display("FAIL drain_hold done=%b ready=%b exp 0/0", drain_done, fetch_ready);
        end
        drain_req = 1'b0;
        tick();
        tests++;
        if (fetch_ready !== 1'b1 || drain_done !== 1'b0) begin
            fails++;
            $display("FAIL drain_exit ready=%b done=%b exp 1/0", fetch_ready, drain_done);
        end
        // Empty window, request dropped while draining: must still complete.
        drain_req = 1'b1;
        tick();
        drain_req = 1'b0;
        tick();
        tests++;
        if (drain_done !== 1'b1 || fetch_ready !== 1'b0) begin
            fails++;
            $display("FAIL drain_empty done=%b ready=%b exp 1/0", drain_done, fetch_ready);
        end
        tick();
        tests++;
        if (drain_done !== 1'b0 || fetch_ready !== 1'b1) begin
            fails++;
            $display("FAIL drain_empty_exit done=%b ready=%b exp 0/1", drain_done, fetch_ready);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            fetch_one(32'hC0 + 32'(i));
        end
        issue_one(4'd0);
        tests++;
        if (issued_valid !== 1'b1 || occupancy !== 5'd3) begin
            fails++;
            $display("FAIL areset_pre iv=%b occ=%0d exp 1/3", issued_valid, occupancy);
        end
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if (issued_valid !== 1'b0 || valid_entries !== 16'h0 || occupancy !== 5'd0
            || core_index !== 4'd0 || fetch_ready !== 1'b0) begin
            fails++;
            $display("FAIL areset_clear iv=%b valid=%h occ=%0d idx=%0d ready=%b exp 0/0000/0/0/0",
                     issued_valid, valid_entries, occupancy, core_index, fetch_ready);
        end
        #3;
        rst = 1'b1;
        fetch_one(32'h7777);
        tests++;
        if (core_wr !== 1'b1 || core_index !== 4'd0 || core_instr !== 32'h7777) begin
            fails++;
            $display("FAIL areset_refill wr=%b idx=%0d instr=%h exp 1/0/00007777",
                     core_wr, core_index, core_instr);
        end
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        rst         = 1'b0;
        fetch_valid = 1'b0;
        fetch_instr = '0;
        issue_valid = 1'b0;
        issue_index = '0;
        drain_req   = 1'b0;
        test_reset();
        test_fill();
        test_issue_free();
        test_simultaneous();
        test_back_to_back();
        test_empty_issue();
        test_drain();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
